// File: rtl/bcd_scan_display.sv
// Two-digit multiplexed 7-segment driver for a packed BCD count. The count is captured once per
// scan frame so both digits always come from the same value.
module bcd_scan_display #(
    parameter int unsigned SCAN_DIV = 4
) (
    input  logic       clk_i,
    input  logic       reset_ni,
    input  logic [7:0] bcd_in_i,
    input  logic       blank_lead_i,
    output logic [6:0] seg_o,
    output logic [1:0] an_o,
    output logic       err_o
);

    localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(SCAN_DIV - 1);

    logic [CntW-1:0] div_q, div_d;
    logic            dsel_q, dsel_d;
    logic [7:0]      frame_q, frame_d;
    logic [6:0]      seg_q, seg_d;
    logic [1:0]      an_q, an_d;
    logic            err_q, err_d;
    logic            tick;
    logic [3:0]      nibble;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        unique case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h40;
        endcase
        return s;
    endfunction

    assign tick = (div_q == CntMax);

    always_comb begin
        div_d   = tick ? '0 : div_q + 1'b1;
        dsel_d  = dsel_q;
        frame_d = frame_q;
        seg_d   = seg_q;
        an_d    = an_q;
        err_d   = err_q;
        // The ones digit at frame start comes straight from the fresh sample, not the old frame.
        nibble  = dsel_q ? bcd_in_i[3:0] : frame_q[7:4];
        if (tick) begin
            dsel_d = ~dsel_q;
            if (dsel_q) begin
                frame_d = bcd_in_i;
                err_d   = (bcd_in_i[7:4] > 4'd9) | (bcd_in_i[3:0] > 4'd9);
                an_d    = 2'b01;
                seg_d   = seg_decode(nibble);
            end else if (blank_lead_i && frame_q[7:4] == 4'd0) begin
                an_d  = 2'b00;
                seg_d = 7'h00;
            end else begin
                an_d  = 2'b10;
                seg_d = seg_decode(nibble);
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            div_q   <= '0;
            dsel_q  <= 1'b1;
            frame_q <= 8'h00;
            seg_q   <= 7'h00;
            an_q    <= 2'b00;
            err_q   <= 1'b0;
        end else begin
            div_q   <= div_d;
            dsel_q  <= dsel_d;
            frame_q <= frame_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
            err_q   <= err_d;
        end
    end

    assign seg_o = seg_q;
    assign an_o  = an_q;
    assign err_o = err_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Randomized and directed bench for bcd_scan_display; two instances (SCAN_DIV 4 and 1) are
// checked each cycle against an edge-counting reference model.
module tb_bcd_scan_display;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] bcd;
    logic       blank;
    logic [6:0] seg4, seg1;
    logic [1:0] an4, an1;
    logic       err4, err1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    bcd_scan_display #(.SCAN_DIV(4)) u_dut4 (
        .clk_i(clk), .reset_ni(rst_n), .bcd_in_i(bcd), .blank_lead_i(blank),
        .seg_o(seg4), .an_o(an4), .err_o(err4)
    );

    bcd_scan_display #(.SCAN_DIV(1)) u_dut1 (
        .clk_i(clk), .reset_ni(rst_n), .bcd_in_i(bcd), .blank_lead_i(blank),
        .seg_o(seg1), .an_o(an1), .err_o(err1)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: counts edges since reset release; every SCAN_DIV-th edge is a tick,
    // odd ticks are frame starts (ones), even ticks show tens of the captured frame.
    int unsigned sd   [2] = '{4, 1};
    int unsigned ecnt [2];
    logic [7:0]  mframe [2];
    logic [6:0]  mseg [2];
    logic [1:0]  man  [2];
    logic        merr [2];

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        logic [6:0] tbl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        if (d < 4'd10) return tbl[d];
        return 7'h40;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            ecnt[i] = 0; mframe[i] = 8'h00; mseg[i] = 7'h00; man[i] = 2'b00; merr[i] = 1'b0;
        end
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int i = 0; i < 2; i++) begin
            ecnt[i]++;
            if (ecnt[i] % sd[i] == 0) begin
                if ((ecnt[i] / sd[i]) % 2 == 1) begin
                    mframe[i] = bcd;
                    merr[i]   = (bcd[7:4] > 9) || (bcd[3:0] > 9);
                    man[i]    = 2'b01;
                    mseg[i]   = seg_of(bcd[3:0]);
                end else if (blank && mframe[i][7:4] == 0) begin
                    man[i]  = 2'b00;
                    mseg[i] = 7'h00;
                end else begin
                    man[i]  = 2'b10;
                    mseg[i] = seg_of(mframe[i][7:4]);
                end
            end
        end
    endtask

    task automatic check_all();
        check("seg_div4", {1'b0, seg4}, {1'b0, mseg[0]});
        check("an_div4",  {6'd0, an4},  {6'd0, man[0]});
        check("err_div4", {7'd0, err4}, {7'd0, merr[0]});
        check("seg_div1", {1'b0, seg1}, {1'b0, mseg[1]});
        check("an_div1",  {6'd0, an1},  {6'd0, man[1]});
        check("err_div1", {7'd0, err1}, {7'd0, merr[1]});
    endtask

    // One clock: model the edge, then sample 1 time unit later.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Assert reset away from a clock edge, check immediate clear, hold two edges, release.
    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_async_seg", {1'b0, seg4}, 8'h00);
        check("rst_async_an",  {6'd0, an4},  8'h00);
        check("rst_async_err", {7'd0, err4}, 8'h00);
        run(2);
        rst_n = 1'b1;
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    initial begin
        rst_n = 1'b0;
        bcd   = 8'h00;
        blank = 1'b0;
        model_reset();
        run(2);
        bcd   = 8'h47;
        rst_n = 1'b1;
        run(3);
        cycle();
        check("e4_seg", {1'b0, seg4}, 8'h07);
        check("e4_an",  {6'd0, an4},  8'h01);
        run(2);
        bcd = 8'h52;
        run(2);
        check("e8_tens_no_tear", {1'b0, seg4}, 8'h66);
        check("e8_an",           {6'd0, an4},  8'h02);
        run(4);
        check("e12_seg", {1'b0, seg4}, 8'h5B);
        run(4);
        check("e16_seg", {1'b0, seg4}, 8'h6D);

        // Blanking, invalid BCD and recovery.
        bcd = 8'h05; blank = 1'b1; run(16);
        blank = 1'b0;              run(16);
        bcd = 8'h00; blank = 1'b1; run(16);
        bcd = 8'h3C; blank = 1'b0; run(16);
        check("err_held", {7'd0, err4}, 8'h01);
        bcd = 8'h12;               run(16);
        check("err_cleared", {7'd0, err4}, 8'h00);

        // Counter feed with 99 -> 00 wrap; resync the frame with a reset first.
        pulse_reset();
        blank = 1'b0;
        for (int v = 90; v < 215; v++) begin
            bcd = to_bcd(v % 100);
            run(8);
        end

        // Random traffic, including invalid nibbles and mid-frame resets.
        for (int k = 0; k < 400; k++) begin
            bcd   = 8'($urandom);
            if ($urandom_range(0, 3) != 0) bcd = to_bcd($urandom_range(0, 99));
            if ($urandom_range(0, 3) == 0) bcd[7:4] = 4'h0;
            blank = 1'($urandom);
            if ($urandom_range(0, 30) == 0) pulse_reset();
            run($urandom_range(1, 10));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
